motor_spi_tx: RTL
=================

MOTOR_SPI_TX -- requirements
Module: motor_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sck half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port motor1  input  8  first byte of the frame; sampled at accept.
REQ-005 SHALL have port motor2  input  8  second byte of the frame; sampled at accept.
REQ-006 SHALL have port valid  input  1  frame request.
REQ-007 SHALL have port ready  output  1  high when a request can be accepted.
REQ-008 SHALL have port sck  output  1  SPI clock; idles low.
REQ-009 SHALL have port sdo  output  1  serial data to the slave's sdi.
REQ-010 SHALL have port load  output  1  frame enable, active-low; idles high.
REQ-011 SHALL have port done  output  1  one-clk pulse at frame end.

Function
REQ-012 SHALL accept a frame in a cycle with valid && ready, latching {motor1, motor2} into a 16-bit shift register.
REQ-013 SHALL keep ready high only in IDLE; valid outside IDLE is ignored.
REQ-014 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
REQ-015 On accept, SHALL enter SETUP next cycle: load=0, sck=0, sdo=motor1[7].
REQ-016 SETUP SHALL last CLK_DIV cycles, then raise sck and enter SHIFT.
REQ-017 In SHIFT, sck SHALL toggle every CLK_DIV cycles, with rise k (k=1..16) at CLK_DIV*(2k-1) cycles after load falls.
REQ-018 sdo SHALL change only on sck falling edges, giving order motor1[7]..motor1[0], motor2[7]..motor2[0] with MSB first.
REQ-019 sdo SHALL be stable from at least CLK_DIV cycles before each rising edge until the following falling edge.
REQ-020 After the 16th falling edge (32*CLK_DIV cycles after load falls), SHALL enter HOLD with sck=0 and sdo=0.
REQ-021 HOLD SHALL last CLK_DIV cycles, then drive load=1, pulse done for 1 cycle, and return to IDLE.
REQ-022 The accept-to-done latency SHALL be exactly 1+33*CLK_DIV clk cycles; ready SHALL rise in the cycle done is high.
REQ-023 Back-to-back frames: valid held high SHALL be accepted in the done cycle, and load SHALL stay high for at least 1 cycle between frames.
REQ-024 Exactly 16 rising sck edges SHALL occur per load-low window, with no edges while load is high.
REQ-025 An internal half-period counter SHALL be 8 bits wide and count 0..CLK_DIV-1, then wrap to 0.
REQ-026 An internal bit counter SHALL be 5 bits wide, count falling edges 0..16, and SHALL NOT wrap within a frame.
REQ-027 Input changes on motor1/motor2 after accept SHALL NOT affect the frame in flight.

Reset
REQ-028 reset_n low SHALL immediately force: state=IDLE, sck=0, sdo=0, load=1, done=0, ready=1 (ready rises when reset releases), counters=0, shift register=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with load high at once, and no done pulse.
REQ-030 The first accept SHALL be possible in the first clk edge after reset_n deasserts.

Configuration
REQ-031 With MOTOR_SPI_TX_MISO_EN defined, SHALL add port sdi input 1 and port rx_data output 16.
REQ-032 With MOTOR_SPI_TX_MISO_EN defined, sdi SHALL be sampled on each sck rising edge, shifted in MSB first, and rx_data SHALL update at the done cycle; rx_data SHALL reset to 0.
REQ-033 Without MOTOR_SPI_TX_MISO_EN, the ports sdi and rx_data and their logic SHALL be absent.

Structure
REQ-034 Package motor_spi_pkg SHALL hold the FSM state enum (IDLE, SETUP, SHIFT, HOLD), FRAME_BITS=16 and BYTE_BITS=8.
REQ-035 Sub-module spi_clk_gen (half-period counter plus rise/fall strobes) SHALL be the single sub-module.

Verification
REQ-036 CLK_DIV=4, motor1=8'hA5, motor2=8'h3C -> bench slave reconstructs motor1=A5, motor2=3C; done at 133 cycles after accept.
REQ-037 Count sck rises per frame -> exactly 16, with none while load=1; sdo changes never coincide with sck rises.
REQ-038 valid held high for 3 frames (8'h01/8'h80, 8'hFF/8'h00, 8'h55/8'hAA) -> 3 frames decoded correctly, with load high at least 1 cycle between frames.
REQ-039 reset_n low at rise 9 of a frame -> load=1 and sck=0 the same cycle; no done pulse; next frame after reset decodes correctly.
REQ-040 CLK_DIV=2, motor1=8'h00, motor2=8'h01 -> latency 67 cycles; only the last bit high.
REQ-041 MOTOR_SPI_TX_MISO_EN defined, bench slave returns 16'hBEEF on sdi -> rx_data=16'hBEEF at done.

Source files
------------

// File: rtl/motor_spi_pkg.sv
// Shared types and sizes for the motor SPI frame transmitter.
package motor_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int BYTE_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/motor_spi_tx_clk_gen.sv
// Half-period counter for the SPI clock; emits a tick every CLK_DIV enabled
// cycles, split into rise/fall strobes according to the current sck level.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sck_lvl,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;
  logic [7:0] cnt_s;

  // next half-period count: wraps at LAST, held at zero while disabled
  always_comb begin
    cnt_s = 8'd0;
    if (en && (cnt_r != LAST)) begin
      cnt_s = cnt_r + 8'd1;
    end else begin
      cnt_s = 8'd0;
    end
  end

  // half-period counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign tick = en && (cnt_r == LAST);
  assign rise = tick && !sck_lvl;
  assign fall = tick && sck_lvl;

endmodule

// File: rtl/motor_spi_tx.sv
// Two-byte SPI master frame transmitter for a motor driver (load active-low).
// Optional MISO capture is enabled by defining MOTOR_SPI_TX_MISO_EN.
module motor_spi_tx
  import motor_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BYTE_BITS-1:0] motor1,
  input  logic [BYTE_BITS-1:0] motor2,
  input  logic                 valid,
  output logic                 ready,
  output logic                 sck,
  output logic                 sdo,
  output logic                 load,
  output logic                 done
`ifdef MOTOR_SPI_TX_MISO_EN
  ,
  input  logic                  sdi,
  output logic [FRAME_BITS-1:0] rx_data
`endif
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  state_e                  state_r;
  state_e                  state_s;
  logic [4:0]              bit_cnt_r;
  logic [4:0]              bit_cnt_s;
  logic [FRAME_BITS-1:0]   shreg_r;
  logic [FRAME_BITS-1:0]   shreg_s;
  logic                    sck_s;
  logic                    sdo_s;
  logic                    load_s;
  logic                    done_s;
  logic                    accept_s;
  logic                    tick_s;
  logic                    rise_s;
  logic                    fall_s;

  assign accept_s = valid && ready;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_r != IDLE),
    .sck_lvl (sck),
    .tick    (tick_s),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  // next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shreg_s   = shreg_r;
    sck_s     = sck;
    sdo_s     = sdo;
    load_s    = load;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = SETUP;
          shreg_s   = {motor1, motor2};
          bit_cnt_s = 5'd0;
          load_s    = 1'b0;
          sck_s     = 1'b0;
          sdo_s     = motor1[BYTE_BITS-1];
        end else begin
          load_s = 1'b1;
          sck_s  = 1'b0;
          sdo_s  = 1'b0;
        end
      end
      SETUP: begin
        if (rise_s) begin
          sck_s   = 1'b1;
          state_s = SHIFT;
        end else begin
          sck_s = 1'b0;
        end
      end
      SHIFT: begin
        if (rise_s) begin
          sck_s = 1'b1;
        end else if (fall_s) begin
          // data only moves on the falling edge so it is settled before each rise
          sck_s     = 1'b0;
          bit_cnt_s = bit_cnt_r + 5'd1;
          shreg_s   = shreg_r << 1;
          if (bit_cnt_r == LAST_BIT) begin
            state_s = HOLD;
            sdo_s   = 1'b0;
          end else begin
            sdo_s = shreg_r[FRAME_BITS-2];
          end
        end else begin
          sck_s = sck;
        end
      end
      HOLD: begin
        if (tick_s) begin
          state_s = IDLE;
          load_s  = 1'b1;
          done_s  = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        load_s  = 1'b1;
        sck_s   = 1'b0;
        sdo_s   = 1'b0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= 5'd0;
      shreg_r   <= '0;
      sck       <= 1'b0;
      sdo       <= 1'b0;
      load      <= 1'b1;
      done      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shreg_r   <= shreg_s;
      sck       <= sck_s;
      sdo       <= sdo_s;
      load      <= load_s;
      done      <= done_s;
      ready     <= (state_s == IDLE);
    end
  end

`ifdef MOTOR_SPI_TX_MISO_EN
  logic [FRAME_BITS-1:0] rx_shift_r;
  logic [FRAME_BITS-1:0] rx_shift_s;
  logic [FRAME_BITS-1:0] rx_data_s;

  // slave data is captured on every sck rise (the first rise happens in SETUP)
  always_comb begin
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data;
    if (accept_s) begin
      rx_shift_s = '0;
    end else if (rise_s && ((state_r == SETUP) || (state_r == SHIFT))) begin
      rx_shift_s = (rx_shift_r << 1) | {{(FRAME_BITS-1){1'b0}}, sdi};
    end else begin
      rx_shift_s = rx_shift_r;
    end
    if ((state_r == HOLD) && tick_s) begin
      rx_data_s = rx_shift_r;
    end else begin
      rx_data_s = rx_data;
    end
  end

  // receive shift register and published word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift_r <= '0;
      rx_data    <= '0;
    end else begin
      rx_shift_r <= rx_shift_s;
      rx_data    <= rx_data_s;
    end
  end
`endif

endmodule
